// File: rtl/rt_rgu_scan.sv
// Ray generation unit with built-in raster scanner and N x N stratified
// supersampling; all-or-nothing pipeline with valid/ready output.
module rt_rgu_scan #(
    parameter int FP_WL       = 32,
    parameter int FP_QW       = 16,
    parameter int COORD_W     = 12,
    parameter int SS_LOG2     = 0,
    parameter int PIPE_STAGES = 5,
    localparam int SW = (SS_LOG2 == 0) ? 1 : 2 * SS_LOG2,
    localparam int VW = 3 * FP_WL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic [VW-1:0]      pixel_00_loc,
    input  logic [VW-1:0]      pixel_delta_u,
    input  logic [VW-1:0]      pixel_delta_v,
    input  logic [VW-1:0]      camera_center,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VW-1:0]      ray_origin,
    output logic [VW-1:0]      ray_direction,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [SW-1:0]      out_sample,
    output logic               out_last
);

    localparam int KW = (SS_LOG2 == 0) ? 1 : SS_LOG2;
    localparam logic [KW-1:0] KMAX = KW'((1 << SS_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic               vld;
        logic               last;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SW-1:0]      s;
    } meta_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] w_q, h_q;
    logic [VW-1:0]      p00_q, du_q, dv_q, cc_q;

    logic [KW-1:0]      sx_q, sx_d, sy_q, sy_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [SW-1:0]      s_cur;

    logic done_q, done_d;
    logic start_ok, degen, adv, issue, last_ray, acc_last;

    meta_t            meta_q [1:PIPE_STAGES];
    meta_t            meta_in;
    logic [FP_WL-1:0] u1_q, v1_q, u_d, v_d;
    logic [VW-1:0]    pu_q, pv_q, pu_d, pv_d;
    logic [VW-1:0]    dir_q [3:PIPE_STAGES];
    logic [VW-1:0]    dir_d;

    // Centre of subcell k, relative to the pixel centre: (2k+1)/2^(L+1) - 1/2
    function automatic logic [FP_WL-1:0] sub_off(input logic [KW-1:0] k);
        logic [FP_WL-1:0] odd;
        odd = FP_WL'({k, 1'b1}) << (FP_QW - SS_LOG2 - 1);
        return odd - (FP_WL'(1) << (FP_QW - 1));
    endfunction

    function automatic logic [FP_WL-1:0] fmul(
        input logic [FP_WL-1:0] a,
        input logic [FP_WL-1:0] b
    );
        logic [2*FP_WL-1:0] ea, eb;
        ea = {{FP_WL{a[FP_WL-1]}}, a};
        eb = {{FP_WL{b[FP_WL-1]}}, b};
        return FP_WL'((ea * eb) >> FP_QW);
    endfunction

    generate
        if (SS_LOG2 == 0) begin : g_s1
            assign s_cur = 1'b0;
        end else begin : g_sn
            assign s_cur = {sy_q, sx_q};
        end
    endgenerate

    assign out_valid = meta_q[PIPE_STAGES].vld;
    assign adv       = !out_valid || out_ready;
    assign start_ok  = (state_q == S_IDLE) && start;
    assign degen     = start_ok && ((width == '0) || (height == '0));
    assign acc_last  = out_valid && out_ready && meta_q[PIPE_STAGES].last;
    assign last_ray  = (sx_q == KMAX) && (sy_q == KMAX) &&
                       (x_q == w_q - 1'b1) && (y_q == h_q - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_ok && !degen) state_d = S_RUN;
            S_RUN:   if (issue && last_ray) state_d = S_DRAIN;
            S_DRAIN: if (acc_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        issue  = (state_q == S_RUN) && adv;
        done_d = degen || ((state_q == S_DRAIN) && acc_last);
    end

    // Raster scan: sample innermost, then x, then y
    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        x_d  = x_q;
        y_d  = y_q;
        if (start_ok) begin
            sx_d = '0;
            sy_d = '0;
            x_d  = '0;
            y_d  = '0;
        end else if (issue) begin
            if (sx_q != KMAX) begin
                sx_d = sx_q + 1'b1;
            end else begin
                sx_d = '0;
                if (sy_q != KMAX) begin
                    sy_d = sy_q + 1'b1;
                end else begin
                    sy_d = '0;
                    if (x_q != w_q - 1'b1) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sx_q   <= '0;
            sy_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            done_q <= 1'b0;
            w_q    <= '0;
            h_q    <= '0;
            p00_q  <= '0;
            du_q   <= '0;
            dv_q   <= '0;
            cc_q   <= '0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            x_q    <= x_d;
            y_q    <= y_d;
            done_q <= done_d;
            if (start_ok) begin
                w_q   <= width;
                h_q   <= height;
                p00_q <= pixel_00_loc;
                du_q  <= pixel_delta_u;
                dv_q  <= pixel_delta_v;
                cc_q  <= camera_center;
            end
        end
    end

    always_comb begin
        meta_in.vld  = issue;
        meta_in.last = issue && last_ray;
        meta_in.x    = x_q;
        meta_in.y    = y_q;
        meta_in.s    = s_cur;
        u_d = (FP_WL'(x_q) << FP_QW) + sub_off(sx_q);
        v_d = (FP_WL'(y_q) << FP_QW) + sub_off(sy_q);
    end

    always_comb begin
        pu_d  = '0;
        pv_d  = '0;
        dir_d = '0;
        for (int i = 0; i < 3; i++) begin
            pu_d[i*FP_WL +: FP_WL]  = fmul(u1_q, du_q[i*FP_WL +: FP_WL]);
            pv_d[i*FP_WL +: FP_WL]  = fmul(v1_q, dv_q[i*FP_WL +: FP_WL]);
            dir_d[i*FP_WL +: FP_WL] = p00_q[i*FP_WL +: FP_WL]
                                    + pu_q[i*FP_WL +: FP_WL]
                                    + pv_q[i*FP_WL +: FP_WL]
                                    - cc_q[i*FP_WL +: FP_WL];
        end
    end

    // Single global enable: every stage moves together or holds
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= PIPE_STAGES; k++) meta_q[k] <= '0;
            for (int k = 3; k <= PIPE_STAGES; k++) dir_q[k] <= '0;
            u1_q <= '0;
            v1_q <= '0;
            pu_q <= '0;
            pv_q <= '0;
        end else if (adv) begin
            meta_q[1] <= meta_in;
            for (int k = 2; k <= PIPE_STAGES; k++) meta_q[k] <= meta_q[k-1];
            u1_q     <= u_d;
            v1_q     <= v_d;
            pu_q     <= pu_d;
            pv_q     <= pv_d;
            dir_q[3] <= dir_d;
            for (int k = 4; k <= PIPE_STAGES; k++) dir_q[k] <= dir_q[k-1];
        end
    end

    assign done          = done_q;
    assign ray_origin    = cc_q;
    assign ray_direction = dir_q[PIPE_STAGES];
    assign out_x         = meta_q[PIPE_STAGES].x;
    assign out_y         = meta_q[PIPE_STAGES].y;
    assign out_sample    = meta_q[PIPE_STAGES].s;
    assign out_last      = meta_q[PIPE_STAGES].last;

endmodule

// File: tb/tb_rt_rgu_scan.sv
// Scoreboard bench for rt_rgu_scan: one instance without and one with
// 2x2 supersampling, directed frames with hand-computed rays.
module tb_rt_rgu_scan;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  s;
        logic        last;
        logic [95:0] dir;
        logic [95:0] org;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, start0 = 1'b0, rdy0 = 1'b1;
    logic [11:0] w0 = '0, h0 = '0;
    logic [95:0] p0 = '0, u0 = '0, v0 = '0, c0 = '0;
    logic        busy0, done0, ov0, ol0;
    logic [95:0] org0, dir0;
    logic [11:0] ox0, oy0;
    logic [0:0]  os0;

    logic        rst1 = 1'b1, start1 = 1'b0, rdy1 = 1'b1;
    logic [11:0] w1 = '0, h1 = '0;
    logic [95:0] p1 = '0, u1 = '0, v1 = '0, c1 = '0;
    logic        busy1, done1, ov1, ol1;
    logic [95:0] org1, dir1;
    logic [11:0] ox1, oy1;
    logic [1:0]  os1;

    rt_rgu_scan #(.FP_WL(32), .FP_QW(16), .COORD_W(12),
                  .SS_LOG2(0), .PIPE_STAGES(5)) dut0 (
        .clk(clk), .reset(rst0), .start(start0),
        .width(w0), .height(h0),
        .pixel_00_loc(p0), .pixel_delta_u(u0),
        .pixel_delta_v(v0), .camera_center(c0),
        .busy(busy0), .done(done0),
        .out_valid(ov0), .out_ready(rdy0),
        .ray_origin(org0), .ray_direction(dir0),
        .out_x(ox0), .out_y(oy0), .out_sample(os0), .out_last(ol0)
    );

    rt_rgu_scan #(.FP_WL(32), .FP_QW(16), .COORD_W(12),
                  .SS_LOG2(1), .PIPE_STAGES(5)) dut1 (
        .clk(clk), .reset(rst1), .start(start1),
        .width(w1), .height(h1),
        .pixel_00_loc(p1), .pixel_delta_u(u1),
        .pixel_delta_v(v1), .camera_center(c1),
        .busy(busy1), .done(done1),
        .out_valid(ov1), .out_ready(rdy1),
        .ray_origin(org1), .ray_direction(dir1),
        .out_x(ox1), .out_y(oy1), .out_sample(os1), .out_last(ol1)
    );

    int n_chk = 0, n_pass = 0;
    int n_acc0 = 0, n_done0 = 0;
    exp_t q0[$], q1[$];

    task automatic check(input string nm, input logic [95:0] act,
                         input logic [95:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s", nm);
    endtask

    task automatic push(input int d, input logic [11:0] x, input logic [11:0] y,
                        input logic [1:0] s, input logic l,
                        input logic [95:0] dir, input logic [95:0] org);
        exp_t e;
        e.x = x; e.y = y; e.s = s; e.last = l; e.dir = dir; e.org = org;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Ready pattern 1,0,0,1 when backpressure is enabled
    bit       bp_en = 1'b0, rdy_force = 1'b1;
    bit [3:0] pat = 4'b1001;
    int       ph = 0;
    always @(posedge clk) begin
        #2;
        rdy0 = bp_en ? pat[ph] : rdy_force;
        ph = (ph + 1) % 4;
    end

    logic        stall_p = 1'b0;
    logic [95:0] s_dir, s_org;
    logic [36:0] s_meta;
    always @(negedge clk) begin
        exp_t e;
        if (done0) n_done0++;
        if (stall_p) begin
            check("hold_dir", dir0, s_dir);
            check("hold_org", org0, s_org);
            check("hold_meta", 96'({ov0, ol0, ox0, oy0, os0}), 96'(s_meta));
        end
        if (ov0 && rdy0 && !rst0) begin
            n_acc0++;
            if (q0.size() == 0) begin
                fail("unexpected_ray0");
            end else begin
                e = q0.pop_front();
                check("ray0_dir", dir0, e.dir);
                check("ray0_org", org0, e.org);
                check("ray0_meta", 96'({ox0, oy0, os0, ol0}),
                      96'({e.x, e.y, e.s[0], e.last}));
            end
        end
        stall_p = ov0 && !rdy0 && !rst0;
        s_dir   = dir0;
        s_org   = org0;
        s_meta  = {ov0, ol0, ox0, oy0, os0};
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov1 && rdy1 && !rst1) begin
            if (q1.size() == 0) begin
                fail("unexpected_ray1");
            end else begin
                e = q1.pop_front();
                check("ray1_dir", dir1, e.dir);
                check("ray1_meta", 96'({ox1, oy1, os1, ol1}),
                      96'({e.x, e.y, e.s, e.last}));
            end
        end
    end

    task automatic cfg0(input logic [11:0] w, input logic [11:0] h,
                        input logic [95:0] p, input logic [95:0] u,
                        input logic [95:0] v, input logic [95:0] c);
        w0 = w; h0 = h; p0 = p; u0 = u; v0 = v; c0 = c;
    endtask

    task automatic cfg_basic();
        cfg0(12'd2, 12'd2, {32'hFFFF0000, 32'h0, 32'h0},
             {32'h0, 32'h0, 32'h00010000}, {32'h0, 32'h00010000, 32'h0}, '0);
    endtask

    task automatic push_basic();
        push(0, 0, 0, 0, 0, {32'hFFFF0000, 32'h0, 32'h0}, '0);
        push(0, 1, 0, 0, 0, {32'hFFFF0000, 32'h0, 32'h00010000}, '0);
        push(0, 0, 1, 0, 0, {32'hFFFF0000, 32'h00010000, 32'h0}, '0);
        push(0, 1, 1, 0, 1, {32'hFFFF0000, 32'h00010000, 32'h00010000}, '0);
    endtask

    task automatic start_pulse0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic wait_done(input int d, input string nm);
        int n = 0;
        while (!(d == 0 ? done0 : done1) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(d == 0 ? done0 : done1)) begin
            fail({nm, "_done_timeout"});
        end else begin
            check({nm, "_busy_at_done"}, 96'(d == 0 ? busy0 : busy1), 96'(0));
            check({nm, "_all_rays_seen"},
                  96'(d == 0 ? q0.size() : q1.size()), 96'(0));
            @(posedge clk); #1;
            check({nm, "_done_one_cycle"}, 96'(d == 0 ? done0 : done1), 96'(0));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, base, dn;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_busy_done", 96'({ov0, busy0, done0}), 96'(0));
        check("rst_dir", dir0, '0);
        check("rst_org", org0, '0);
        check("rst_meta", 96'({ox0, oy0, os0, ol0}), 96'(0));
        rst0 = 1'b0;
        rst1 = 1'b0;

        // basic frame with latency measurement
        cfg_basic();
        push_basic();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        n = 0;
        while (!ov0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 96'(n), 96'(5));
        check("busy_in_frame", 96'(busy0), 96'(1));
        wait_done(0, "basic");

        // 2x2 supersampling, one pixel
        w1 = 12'd1; h1 = 12'd1;
        p1 = {32'hFFFF0000, 32'h0, 32'h0};
        u1 = {32'h0, 32'h0, 32'h00010000};
        v1 = {32'h0, 32'h00010000, 32'h0};
        c1 = '0;
        push(1, 0, 0, 0, 0, {32'hFFFF0000, 32'hFFFFC000, 32'hFFFFC000}, '0);
        push(1, 0, 0, 1, 0, {32'hFFFF0000, 32'hFFFFC000, 32'h00004000}, '0);
        push(1, 0, 0, 2, 0, {32'hFFFF0000, 32'h00004000, 32'hFFFFC000}, '0);
        push(1, 0, 0, 3, 1, {32'hFFFF0000, 32'h00004000, 32'h00004000}, '0);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        wait_done(1, "ss");

        // backpressure
        bp_en = 1'b1;
        push_basic();
        start_pulse0();
        wait_done(0, "bp");
        bp_en = 1'b0;
        repeat (2) @(posedge clk);

        // degenerate frame
        cfg0(12'd0, 12'd2, '0, '0, '0, '0);
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        check("degen_done", 96'(done0), 96'(1));
        check("degen_busy", 96'(busy0), 96'(0));
        @(posedge clk); #1;
        check("degen_done_pulse", 96'(done0), 96'(0));
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov0 || busy0) seen = 1'b1;
        end
        check("degen_quiet", 96'(seen), 96'(0));

        // start while busy is ignored
        cfg_basic();
        push_basic();
        base = n_acc0;
        start_pulse0();
        repeat (3) @(posedge clk);
        #1 w0 = 12'd5; h0 = 12'd5; start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        wait_done(0, "ign");
        repeat (10) @(posedge clk);
        #1 check("ign_ray_count", 96'(n_acc0 - base), 96'(4));

        // reset mid-frame
        cfg_basic();
        push_basic();
        base = n_acc0;
        start_pulse0();
        n = 0;
        while (n_acc0 < base + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n_acc0 < base + 2) fail("rst_wait_timeout");
        #1 rst0 = 1'b1;
        rdy_force = 1'b0;
        dn = n_done0;
        @(posedge clk); #1;
        check("midrst_state", 96'({ov0, busy0, done0}), 96'(0));
        rst0 = 1'b0;
        rdy_force = 1'b1;
        q0.delete();
        repeat (10) @(posedge clk);
        #1 check("midrst_no_done", 96'(n_done0), 96'(dn));
        push_basic();
        start_pulse0();
        wait_done(0, "after_rst");

        // offset camera
        cfg0(12'd3, 12'd1, {32'hFFFF0000, 32'h0, 32'h00010000},
             {32'h0, 32'h0, 32'h00008000}, {32'h0, 32'h00008000, 32'h0},
             {32'h0, 32'h0, 32'h00010000});
        push(0, 0, 0, 0, 0, {32'hFFFF0000, 32'h0, 32'h0},
             {32'h0, 32'h0, 32'h00010000});
        push(0, 1, 0, 0, 0, {32'hFFFF0000, 32'h0, 32'h00008000},
             {32'h0, 32'h0, 32'h00010000});
        push(0, 2, 0, 0, 1, {32'hFFFF0000, 32'h0, 32'h00010000},
             {32'h0, 32'h0, 32'h00010000});
        start_pulse0();
        wait_done(0, "offset");

        repeat (5) @(posedge clk);
        #1;
        check("final_q0_empty", 96'(q0.size()), 96'(0));
        check("final_q1_empty", 96'(q1.size()), 96'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rt_rgu_scan.md
Name: rt_rgu_scan

Overview:
- Parametrised successor to the 5-stage ray generation unit.
- Adds an internal frame scanner, so one start pulse generates every ray of a frame (raster order).
- Supports configurable stratified supersampling (N×N subpixel grid per pixel), configurable pipeline depth, and a valid/ready output handshake with full backpressure.
- Feeds the intersection stage directly.

Parameters:
- FP_WL, 32, fixed-point word length (signed two's complement).
- FP_QW, 16, fractional bits.
- COORD_W, 12, pixel coordinate width.
- SS_LOG2, 0, log2 of subsamples per axis; samples per pixel = 4^SS_LOG2; legal range 0..3.
- PIPE_STAGES, 5, issue-to-output latency in cycles; legal range 3..8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: latch frame config and begin scanning
- width  in  COORD_W  image width in pixels
- height  in  COORD_W  image height in pixels
- pixel_00_loc  in  3*FP_WL  centre of pixel (0,0); component i at [i*FP_WL +: FP_WL], i=0 is x
- pixel_delta_u  in  3*FP_WL  per-pixel step in x
- pixel_delta_v  in  3*FP_WL  per-pixel step in y
- camera_center  in  3*FP_WL  ray origin
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the last ray has been accepted
- out_valid  out  1  ray output valid
- out_ready  in  1  downstream accepts the ray
- ray_origin  out  3*FP_WL  ray origin
- ray_direction  out  3*FP_WL  ray direction
- out_x  out  COORD_W  pixel x of the ray
- out_y  out  COORD_W  pixel y of the ray
- out_sample  out  2*SS_LOG2 (min 1)  sample index
- out_last  out  1  last ray of the frame

Behaviour:
- Reset: all outputs 0, pipeline valid bits cleared, FSM to IDLE.
  - A reset asserted mid-frame abandons the frame immediately. No done pulse is produced.
- Frame config latch: on a start accepted in IDLE, width, height and the four vectors are latched. Input changes during the frame are ignored.
- start while busy is ignored.
- FSM:
  - IDLE: on start:
    - width==0 or height==0: done pulses the next cycle, busy stays 0, FSM stays IDLE.
    - Otherwise go to RUN; busy=1 from the next cycle.
  - RUN: one ray is issued into stage 1 on every cycle the pipeline advances.
    - Order, innermost first: sample index s, then x, then y.
    - After the ray (width-1, height-1, last s) is issued, go to DRAIN.
  - DRAIN: no issue. When the out_last ray handshakes (out_valid && out_ready): done=1 for one cycle, busy=0, FSM to IDLE in the same cycle.
- Sample index: s = {sy, sx}, where sx and sy each run 0..2^SS_LOG2-1 and sx is the LSBs.
- Subpixel offset per axis: off = (2*k+1)/2^(SS_LOG2+1) - 0.5 pixels, in FP_QW format, where k is sx or sy.
  - SS_LOG2=0 gives offset 0.
- Arithmetic, per component i:
  - u = x + off_x and v = y + off_y, in FP format.
  - dir_i = p00_i + u*du_i + v*dv_i - cc_i.
  - Products are full 2*FP_WL wide, then take bits [FP_QW +: FP_WL]. This truncates toward -inf.
  - Sums wrap modulo 2^FP_WL; no saturation.
  - ray_origin = latched camera_center.
- Pipeline:
  - Exactly PIPE_STAGES cycles from issue to out_valid when there is no stall.
  - Global stall: when out_valid && !out_ready, all stages and the scanner hold. Output registers hold their values stable.
  - Stages without valid data do not block (bubble collapse is not required; the pipeline is all-or-nothing).
  - Throughput is 1 ray/cycle with out_ready held high.
- out_last=1 only on the final ray of the frame.
- Frame ray count = width*height*4^SS_LOG2.

Test Plan:
- Basic frame and latency: FP 32/16, SS_LOG2=0, p00=(0,0,-1), du=(1,0,0), dv=(0,1,0), cc=0, width=2, height=2, out_ready=1, start.
  - 4 rays in order: direction x/y = (0,0), (0x00010000,0), (0,0x00010000), (0x00010000,0x00010000); z=0xFFFF0000 on all.
  - First out_valid exactly 5 cycles after issue.
  - out_last on ray 4; done pulses 1 cycle; busy falls.
- Supersampling: SS_LOG2=1, same camera, width=1, height=1.
  - 4 rays, s=0..3, with (dx,dy) = (0xFFFFC000,0xFFFFC000), (0x00004000,0xFFFFC000), (0xFFFFC000,0x00004000), (0x00004000,0x00004000).
- Backpressure: the basic frame with out_ready toggled 1,0,0,1 repeatedly.
  - Outputs hold stable while stalled.
  - No ray lost or duplicated; still exactly 4 rays, in order.
- Degenerate frame and ignored start:
  - width=0: done pulses the next cycle, out_valid never set.
  - A start during busy with width=5: frame still produces 4 rays.
- Reset mid-frame: reset asserted after 2 rays.
  - Next cycle: out_valid=0, busy=0, no done.
  - A new start runs a full correct frame.
- Offset camera: cc=(0x00010000,0,0), p00=(0x00010000,0,-1), du=(0x00008000,0,0), dv=(0,0x00008000,0), width=3, height=1.
  - x directions 0, 0x8000, 0x10000.
  - ray_origin x = 0x00010000 on every ray.
